// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter and its
// 7-segment decoders.
package bcd_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    function automatic logic [3:0] add3_adjust(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// One BCD digit to 7-segment pattern; codes above 9 show a dash so a corrupted
// digit is visible on the display instead of looking like a valid number.
module seg7_digit
    import bcd_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] seg_hi;

    always_comb begin
        seg_hi = SEG_DASH;
        if (blank) begin
            seg_hi = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg_hi = SEG_0;
                4'd1:    seg_hi = SEG_1;
                4'd2:    seg_hi = SEG_2;
                4'd3:    seg_hi = SEG_3;
                4'd4:    seg_hi = SEG_4;
                4'd5:    seg_hi = SEG_5;
                4'd6:    seg_hi = SEG_6;
                4'd7:    seg_hi = SEG_7;
                4'd8:    seg_hi = SEG_8;
                4'd9:    seg_hi = SEG_9;
                default: seg_hi = SEG_DASH;
            endcase
        end
    end

    assign seg = ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/bin2bcd_seq_decoder.sv
// Double-dabble binary-to-BCD converter (one bit per clock) with a held result
// register and per-digit 7-segment decode, optional leading-zero blanking.
module bin2bcd_seq_decoder
    import bcd_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    binary,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic [7*DIGITS-1:0] seg
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (64'(10) ** DIGITS < (64'(1) << WIDTH)) begin : g_range_check
        $fatal(1, "bin2bcd_seq_decoder: DIGITS too small for WIDTH");
    end

    // Handshake: start is sampled only while idle (busy=0) together with binary;
    // done pulses for one cycle when bcd/seg take the new result, and start may
    // be raised in that same cycle to begin the next conversion immediately.
    state_t          state, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    scratch_sh;
    logic [WIDTH-1:0] shift_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            scratch_q <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state     <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            scratch_q <= scratch_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
        end
    end

    // Adjust every digit on its pre-shift value, then shift {scratch, shift} left.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = add3_adjust(scratch_q[4*i +: 4]);
        end
        scratch_sh = {adj[BW-2:0], shift_q[WIDTH-1]};
        shift_sh   = shift_q << 1;
    end

    always_comb begin
        state_d   = state;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        scratch_d = scratch_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        case (state)
            IDLE: begin
                if (start) begin
                    shift_d   = binary;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH - 1);
                    busy_d    = 1'b1;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                scratch_d = scratch_sh;
                shift_d   = shift_sh;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    bcd_d   = scratch_sh;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

    // Digit i>0 blanks only when it and every digit above it are zero.
    logic [DIGITS-1:0] blank;
    logic              zero_above;

    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (bcd_q[4*i +: 4] == 4'd0);
            blank[i]   = BLANK_LZ & zero_above;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_digit #(
            .ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_seg (
            .bcd  (bcd_q[4*g +: 4]),
            .blank(blank[g]),
            .seg  (seg[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_bin2bcd_seq_decoder.sv
// Bench for bin2bcd_seq_decoder: 8-bit/3-digit instances with and without
// leading-zero blanking, plus a 16-bit/5-digit instance.
module tb_bin2bcd_seq_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic [7:0]  binary8 = '0;
    logic [15:0] binary16 = '0;

    logic        busy8, done8, busy_lz, done_lz, busy16, done16;
    logic [11:0] bcd8, bcd_lz;
    logic [20:0] seg8, seg_lz;
    logic [19:0] bcd16;
    logic [34:0] seg16;

    logic [19:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_decoder #(.WIDTH(8), .DIGITS(3), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start8), .binary(binary8),
        .busy(busy8), .done(done8), .bcd(bcd8), .seg(seg8));

    bin2bcd_seq_decoder #(.WIDTH(8), .DIGITS(3), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) u_lz (
        .clk(clk), .rst_n(rst_n), .start(start8), .binary(binary8),
        .busy(busy_lz), .done(done_lz), .bcd(bcd_lz), .seg(seg_lz));

    bin2bcd_seq_decoder #(.WIDTH(16), .DIGITS(5), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .binary(binary16),
        .busy(busy16), .done(done16), .bcd(bcd16), .seg(seg16));

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_model(input logic [3:0] d, input bit blk);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'h3F;  4'd1: s = 7'h06;  4'd2: s = 7'h5B;  4'd3: s = 7'h4F;
            4'd4: s = 7'h66;  4'd5: s = 7'h6D;  4'd6: s = 7'h7D;  4'd7: s = 7'h07;
            4'd8: s = 7'h7F;  4'd9: s = 7'h6F;  default: s = 7'h40;
        endcase
        if (blk) s = 7'h00;
        return ~s;
    endfunction

    function automatic logic [20:0] seg3_model(input int unsigned v, input bit lz);
        logic [19:0] b;
        logic [20:0] s;
        int unsigned p;
        bit          blk;
        b = ref_bcd(v);
        s = '0;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            blk = lz && (i > 0) && (v < p);
            s[7*i +: 7] = seg_model(b[4*i +: 4], blk);
            p = p * 10;
        end
        return s;
    endfunction

    // Drivers: present value and start, return just after the accepting edge.
    task automatic drive8(input logic [7:0] v);
        @(negedge clk);
        binary8 = v;
        start8  = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        exp_q.push_back(ref_bcd(int'(v)));
    endtask

    task automatic drive16(input logic [15:0] v);
        @(negedge clk);
        binary16 = v;
        start16  = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        exp_q.push_back(ref_bcd(int'(v)));
    endtask

    task automatic wait_done8(output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        while (cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done8) begin
                if (busy8) busy_ok = 1'b0;
                break;
            end
            if (!busy8) busy_ok = 1'b0;
        end
    endtask

    task automatic wait_done16(output int cyc);
        cyc = 0;
        while (cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done16) break;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy8); end
        n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done8); end
        n_cmp++; if (bcd8 !== 12'h000) begin n_err++; $display("FAIL reset_bcd: got %h expected 000", bcd8); end
        n_cmp++; if (seg8 !== {7'h40, 7'h40, 7'h40}) begin n_err++; $display("FAIL reset_seg: got %h expected %h", seg8, {7'h40, 7'h40, 7'h40}); end
        n_cmp++; if (seg_lz !== {7'h7F, 7'h7F, 7'h40}) begin n_err++; $display("FAIL reset_seg_lz: got %h expected %h", seg_lz, {7'h7F, 7'h7F, 7'h40}); end
        n_cmp++; if (bcd16 !== 20'h0 || busy16 !== 1'b0) begin n_err++; $display("FAIL reset_w16: got bcd %h busy %b expected 0 0", bcd16, busy16); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_max();
        int          cyc;
        bit          busy_ok;
        logic [19:0] exp;
        drive8(8'd255);
        n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL max_busy_start: got %b expected 1", busy8); end
        wait_done8(cyc, busy_ok);
        exp = exp_q.pop_front();
        n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL max_latency: got %0d expected 8", cyc); end
        n_cmp++; if (!busy_ok) begin n_err++; $display("FAIL max_busy_window: got bad busy expected high for 8 cycles"); end
        n_cmp++; if (bcd8 !== exp[11:0]) begin n_err++; $display("FAIL max_bcd: got %h expected %h", bcd8, exp[11:0]); end
        n_cmp++; if (seg8 !== {7'h24, 7'h12, 7'h12}) begin n_err++; $display("FAIL max_seg: got %h expected %h", seg8, {7'h24, 7'h12, 7'h12}); end
        @(negedge clk);
        n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL max_done_pulse: got %b expected 0", done8); end
        n_cmp++; if (bcd8 !== exp[11:0]) begin n_err++; $display("FAIL max_bcd_hold: got %h expected %h", bcd8, exp[11:0]); end
    endtask

    task automatic test_legacy();
        int          cyc;
        bit          busy_ok;
        logic [19:0] exp;
        logic [7:0]  vals[2] = '{8'd15, 8'd10};
        foreach (vals[k]) begin
            drive8(vals[k]);
            wait_done8(cyc, busy_ok);
            exp = exp_q.pop_front();
            n_cmp++; if (bcd8 !== exp[11:0]) begin n_err++; $display("FAIL legacy_bcd: got %h expected %h", bcd8, exp[11:0]); end
            n_cmp++; if (seg8 !== seg3_model(vals[k], 1'b0)) begin n_err++; $display("FAIL legacy_seg: got %h expected %h", seg8, seg3_model(vals[k], 1'b0)); end
            n_cmp++; if (seg_lz !== seg3_model(vals[k], 1'b1)) begin n_err++; $display("FAIL legacy_seg_lz: got %h expected %h", seg_lz, seg3_model(vals[k], 1'b1)); end
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        bit          busy_ok;
        logic [19:0] exp;
        @(negedge clk);
        binary8 = 8'd200;
        start8  = 1'b1;
        exp_q.push_back(ref_bcd(200));
        @(posedge clk);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            cyc++;
            if (cyc == 4) begin
                #1 binary8 = 8'd99;
            end
            @(negedge clk);
            if (done8) break;
        end
        exp = exp_q.pop_front();
        n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL b2b_latency1: got %0d expected 8", cyc); end
        n_cmp++; if (bcd8 !== exp[11:0]) begin n_err++; $display("FAIL b2b_captured: got %h expected %h", bcd8, exp[11:0]); end
        exp_q.push_back(ref_bcd(99));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL b2b_accept_in_done: got busy %b expected 1", busy8); end
        wait_done8(cyc, busy_ok);
        exp = exp_q.pop_front();
        n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL b2b_latency2: got %0d expected 8", cyc); end
        n_cmp++; if (bcd8 !== exp[11:0]) begin n_err++; $display("FAIL b2b_second: got %h expected %h", bcd8, exp[11:0]); end
    endtask

    task automatic test_reset_mid();
        int          cyc;
        bit          busy_ok;
        bit          saw_done;
        logic [19:0] exp;
        drive8(8'd77);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_cmp++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_err++; $display("FAIL rstmid_flags: got busy %b done %b expected 0 0", busy8, done8); end
        n_cmp++; if (bcd8 !== 12'h000) begin n_err++; $display("FAIL rstmid_bcd: got %h expected 000", bcd8); end
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done: got done pulse expected none"); end
        drive8(8'd128);
        wait_done8(cyc, busy_ok);
        exp = exp_q.pop_front();
        n_cmp++; if (bcd8 !== 12'h128 || bcd8 !== exp[11:0]) begin n_err++; $display("FAIL rstmid_after: got %h expected %h", bcd8, exp[11:0]); end
        n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL rstmid_latency: got %0d expected 8", cyc); end
    endtask

    task automatic test_sweep();
        int          cyc;
        bit          busy_ok;
        logic [19:0] exp;
        for (int v = 0; v < 256; v++) begin
            drive8(8'(v));
            wait_done8(cyc, busy_ok);
            exp = exp_q.pop_front();
            n_cmp++; if (bcd8 !== exp[11:0] || cyc !== 8) begin n_err++; $display("FAIL sweep_bcd v=%0d: got %h lat %0d expected %h lat 8", v, bcd8, cyc, exp[11:0]); end
            n_cmp++; if (seg8 !== seg3_model(v, 1'b0)) begin n_err++; $display("FAIL sweep_seg v=%0d: got %h expected %h", v, seg8, seg3_model(v, 1'b0)); end
            n_cmp++; if (seg_lz !== seg3_model(v, 1'b1)) begin n_err++; $display("FAIL sweep_seg_lz v=%0d: got %h expected %h", v, seg_lz, seg3_model(v, 1'b1)); end
        end
    endtask

    task automatic test_wide();
        int          cyc;
        logic [19:0] exp;
        logic [15:0] v;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0:       v = 16'd0;
                1:       v = 16'd9999;
                2:       v = 16'd65535;
                default: v = 16'($urandom_range(0, 65535));
            endcase
            drive16(v);
            wait_done16(cyc);
            exp = exp_q.pop_front();
            n_cmp++; if (bcd16 !== exp || cyc !== 16) begin n_err++; $display("FAIL wide_bcd v=%0d: got %h lat %0d expected %h lat 16", v, bcd16, cyc, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_legacy();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
